// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// One access is in flight at a time, and every output is registered.
module sram_port_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_wdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_wdata,
   output logic        a_gnt,
   output logic        b_gnt,
   output logic        a_done,
   output logic        b_done,
   output logic [31:0] a_rdata,
   output logic [31:0] b_rdata,
   output logic        sram_csb_n,
   output logic        sram_we_n,
   output logic [4:0]  sram_addr,
   output logic [31:0] sram_din,
   input  logic [31:0] sram_dout
);

   localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t     state;
   logic       ptr_b;
   logic       win_b;
   logic       lat_we;
   logic [1:0] wait_cnt;
   logic       pick_b;

   // B wins when it asks alone, or when both ask and the pointer favours B.
   assign pick_b = b_req & (~a_req | ptr_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr_b      <= 1'b0;
         win_b      <= 1'b0;
         lat_we     <= 1'b0;
         wait_cnt   <= '0;
         a_gnt      <= 1'b0;
         b_gnt      <= 1'b0;
         a_done     <= 1'b0;
         b_done     <= 1'b0;
         a_rdata    <= '0;
         b_rdata    <= '0;
         sram_csb_n <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_addr  <= '0;
         sram_din   <= '0;
      end else begin
         a_gnt  <= 1'b0;
         b_gnt  <= 1'b0;
         a_done <= 1'b0;
         b_done <= 1'b0;
         case (state)
            IDLE: begin
               if (a_req | b_req) begin
                  win_b      <= pick_b;
                  ptr_b      <= ~pick_b;
                  lat_we     <= pick_b ? b_we : a_we;
                  a_gnt      <= ~pick_b;
                  b_gnt      <= pick_b;
                  sram_csb_n <= 1'b0;
                  sram_we_n  <= pick_b ? ~b_we : ~a_we;
                  sram_addr  <= pick_b ? b_addr : a_addr;
                  sram_din   <= pick_b ? b_wdata : a_wdata;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               sram_csb_n <= 1'b1;
               sram_we_n  <= 1'b1;
               wait_cnt   <= '0;
               if (lat_we) begin
                  a_done <= ~win_b;
                  b_done <= win_b;
                  state  <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               // Read data is valid on the last wait cycle only.
               if (wait_cnt == WAIT_LAST) begin
                  if (win_b) b_rdata <= sram_dout;
                  else       a_rdata <= sram_dout;
                  a_done <= ~win_b;
                  b_done <= win_b;
                  state  <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one instance at RD_LAT=1 with a RAM model,
// one at RD_LAT=3 with an address-pattern ROM model.
module tb_sram_port_arbiter;

   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_req, a_we, b_req, b_we;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_done, b_done;
   logic [31:0] a_rdata, b_rdata;
   logic        sram_csb_n, sram_we_n;
   logic [4:0]  sram_addr;
   logic [31:0] sram_din, sram_dout;

   logic        t3_a_req, t3_a_we, t3_b_req, t3_b_we;
   logic [4:0]  t3_a_addr, t3_b_addr;
   logic [31:0] t3_a_wdata, t3_b_wdata;
   logic        t3_a_gnt, t3_b_gnt, t3_a_done, t3_b_done;
   logic [31:0] t3_a_rdata, t3_b_rdata;
   logic        t3_sram_csb_n, t3_sram_we_n;
   logic [4:0]  t3_sram_addr;
   logic [31:0] t3_sram_din, t3_sram_dout;

   sram_port_arbiter #(.RD_LAT(1)) u_dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
      .a_rdata(a_rdata), .b_rdata(b_rdata),
      .sram_csb_n(sram_csb_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   sram_port_arbiter #(.RD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .a_req(t3_a_req), .a_we(t3_a_we), .a_addr(t3_a_addr), .a_wdata(t3_a_wdata),
      .b_req(t3_b_req), .b_we(t3_b_we), .b_addr(t3_b_addr), .b_wdata(t3_b_wdata),
      .a_gnt(t3_a_gnt), .b_gnt(t3_b_gnt), .a_done(t3_a_done), .b_done(t3_b_done),
      .a_rdata(t3_a_rdata), .b_rdata(t3_b_rdata),
      .sram_csb_n(t3_sram_csb_n), .sram_we_n(t3_sram_we_n), .sram_addr(t3_sram_addr),
      .sram_din(t3_sram_din), .sram_dout(t3_sram_dout)
   );

   // Single-cycle-latency RAM; dout holds a junk marker after non-read cycles.
   logic [31:0] mem1 [32];
   logic [31:0] rd1;
   always @(posedge clk) begin
      if (!sram_csb_n && !sram_we_n) mem1[sram_addr] <= sram_din;
      if (!sram_csb_n && sram_we_n) rd1 <= mem1[sram_addr];
      else                          rd1 <= 32'h0BAD_0001;
   end
   assign sram_dout = rd1;

   // Three-stage ROM returning CAFE_00xx for address xx.
   logic [31:0] p3 [3];
   always @(posedge clk) begin
      if (!t3_sram_csb_n && t3_sram_we_n) p3[0] <= {16'hCAFE, 11'd0, t3_sram_addr};
      else                                p3[0] <= 32'h0BAD_0003;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign t3_sram_dout = p3[2];

   typedef struct {
      bit          port_b;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref1 [32];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if ({a_gnt, b_gnt, a_done, b_done} !== 4'b0000) begin n_err++; $display("FAIL rst_pulses: got %b expected 0000", {a_gnt, b_gnt, a_done, b_done}); end
      n_cmp++; if ({a_rdata, b_rdata} !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", {a_rdata, b_rdata}); end
      n_cmp++; if ({sram_csb_n, sram_we_n} !== 2'b11) begin n_err++; $display("FAIL rst_sram_ctl: got %b expected 11", {sram_csb_n, sram_we_n}); end
      n_cmp++; if ({sram_addr, sram_din} !== 37'h0) begin n_err++; $display("FAIL rst_sram_bus: got %h expected 0", {sram_addr, sram_din}); end
      n_cmp++; if ({t3_sram_csb_n, t3_a_gnt, t3_a_done} !== 3'b100) begin n_err++; $display("FAIL rst_lat3: got %b expected 100", {t3_sram_csb_n, t3_a_gnt, t3_a_done}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_a();
      exp_t e;
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'h03; a_wdata = 32'hDEADBEEF;
      ref1[3] = 32'hDEADBEEF;
      sb.push_back('{port_b: 1'b0, data: 32'h0});
      tick();
      n_cmp++; if ({a_gnt, b_gnt} !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b expected 10", {a_gnt, b_gnt}); end
      n_cmp++; if ({sram_csb_n, sram_we_n} !== 2'b00) begin n_err++; $display("FAIL wr_sram_ctl: got %b expected 00", {sram_csb_n, sram_we_n}); end
      n_cmp++; if (sram_addr !== 5'h03 || sram_din !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_sram_bus: got %h/%h expected 03/deadbeef", sram_addr, sram_din); end
      n_cmp++; if ({a_done, b_done} !== 2'b00) begin n_err++; $display("FAIL wr_early_done: got %b expected 00", {a_done, b_done}); end
      a_req = 1'b0;
      tick();
      e = sb.pop_front();
      n_cmp++; if ({a_done, b_done} !== {~e.port_b, e.port_b}) begin n_err++; $display("FAIL wr_done: got %b expected %b", {a_done, b_done}, {~e.port_b, e.port_b}); end
      n_cmp++; if ({a_gnt, b_gnt, sram_csb_n, sram_we_n} !== 4'b0011) begin n_err++; $display("FAIL wr_resp_ctl: got %b expected 0011", {a_gnt, b_gnt, sram_csb_n, sram_we_n}); end
      n_cmp++; if (sram_addr !== 5'h03 || sram_din !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_bus_hold: got %h/%h expected 03/deadbeef", sram_addr, sram_din); end
      tick();
      n_cmp++; if ({a_done, b_done} !== 2'b00) begin n_err++; $display("FAIL wr_done_width: got %b expected 00", {a_done, b_done}); end
   endtask

   task automatic test_read_b();
      exp_t e;
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'h03; b_wdata = 32'h1111_2222;
      sb.push_back('{port_b: 1'b1, data: ref1[3]});
      tick();
      n_cmp++; if ({a_gnt, b_gnt} !== 2'b01) begin n_err++; $display("FAIL rd_gnt: got %b expected 01", {a_gnt, b_gnt}); end
      n_cmp++; if ({sram_csb_n, sram_we_n} !== 2'b01 || sram_addr !== 5'h03) begin n_err++; $display("FAIL rd_issue: got %b/%h expected 01/03", {sram_csb_n, sram_we_n}, sram_addr); end
      b_req = 1'b0;
      tick();
      n_cmp++; if ({a_done, b_done, sram_csb_n} !== 3'b001) begin n_err++; $display("FAIL rd_wait: got %b expected 001", {a_done, b_done, sram_csb_n}); end
      tick();
      e = sb.pop_front();
      n_cmp++; if ({a_done, b_done} !== {~e.port_b, e.port_b}) begin n_err++; $display("FAIL rd_done: got %b expected %b", {a_done, b_done}, {~e.port_b, e.port_b}); end
      n_cmp++; if (b_rdata !== e.data) begin n_err++; $display("FAIL rd_data: got %h expected %h", b_rdata, e.data); end
      n_cmp++; if (a_rdata !== 32'h0) begin n_err++; $display("FAIL rd_other_rdata: got %h expected 0", a_rdata); end
      tick();
   endtask

   task automatic test_round_robin();
      bit   gq[$];
      bit   g;
      exp_t e;
      int   ng = 0;
      int   nd = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'd10; a_wdata = 32'hA1A1_0001;
      b_req = 1'b1; b_we = 1'b1; b_addr = 5'd11; b_wdata = 32'hB2B2_0002;
      ref1[10] = 32'hA1A1_0001;
      ref1[11] = 32'hB2B2_0002;
      for (int k = 0; k < 4; k++) begin
         gq.push_back(k[0]);
         sb.push_back('{port_b: k[0], data: 32'h0});
      end
      for (int c = 1; c <= 12; c++) begin
         tick();
         n_cmp++; if ((a_gnt && b_gnt) || (a_done && b_done)) begin n_err++; $display("FAIL rr_overlap: cycle %0d got gnt %b done %b", c, {a_gnt, b_gnt}, {a_done, b_done}); end
         if (a_gnt || b_gnt) begin
            n_cmp++;
            if (gq.size() == 0) begin
               n_err++; $display("FAIL rr_extra_gnt: cycle %0d got %b expected none", c, {a_gnt, b_gnt});
            end else begin
               g = gq.pop_front();
               if ({a_gnt, b_gnt} !== {~g, g} || c != 1 + 3 * ng) begin
                  n_err++; $display("FAIL rr_gnt: cycle %0d got %b expected %b at cycle %0d", c, {a_gnt, b_gnt}, {~g, g}, 1 + 3 * ng);
               end
            end
            ng++;
         end
         if (a_done || b_done) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL rr_extra_done: cycle %0d got %b expected none", c, {a_done, b_done});
            end else begin
               e = sb.pop_front();
               if ({a_done, b_done} !== {~e.port_b, e.port_b} || c != 2 + 3 * nd) begin
                  n_err++; $display("FAIL rr_done: cycle %0d got %b expected %b at cycle %0d", c, {a_done, b_done}, {~e.port_b, e.port_b}, 2 + 3 * nd);
               end
            end
            nd++;
         end
         if (c == 10) begin a_req = 1'b0; b_req = 1'b0; end
      end
      n_cmp++; if (ng != 4 || nd != 4) begin n_err++; $display("FAIL rr_count: got %0d gnt %0d done expected 4/4", ng, nd); end
      n_cmp++; if ({a_rdata, b_rdata} !== 64'h0) begin n_err++; $display("FAIL rr_rdata_kept: got %h expected 0", {a_rdata, b_rdata}); end
   endtask

   task automatic test_single_req();
      exp_t e;
      // Pointer favours A here, yet a lone B request must win.
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd10;
      sb.push_back('{port_b: 1'b1, data: ref1[10]});
      tick();
      n_cmp++; if ({a_gnt, b_gnt} !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b expected 01", {a_gnt, b_gnt}); end
      b_req = 1'b0;
      tick();
      tick();
      e = sb.pop_front();
      n_cmp++; if (b_done !== 1'b1 || b_rdata !== e.data || a_rdata !== 32'h0) begin n_err++; $display("FAIL single_rd: got %b/%h/%h expected 1/%h/0", b_done, b_rdata, a_rdata, e.data); end
      tick();
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd11;
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd10;
      sb.push_back('{port_b: 1'b0, data: ref1[11]});
      sb.push_back('{port_b: 1'b1, data: ref1[10]});
      tick();
      n_cmp++; if ({a_gnt, b_gnt} !== 2'b10) begin n_err++; $display("FAIL both_gnt_a: got %b expected 10", {a_gnt, b_gnt}); end
      a_req = 1'b0;
      tick();
      tick();
      e = sb.pop_front();
      n_cmp++; if ({a_done, b_done} !== 2'b10 || a_rdata !== e.data) begin n_err++; $display("FAIL both_done_a: got %b/%h expected 10/%h", {a_done, b_done}, a_rdata, e.data); end
      tick();
      tick();
      n_cmp++; if ({a_gnt, b_gnt} !== 2'b01) begin n_err++; $display("FAIL both_gnt_b: got %b expected 01", {a_gnt, b_gnt}); end
      b_req = 1'b0;
      tick();
      tick();
      e = sb.pop_front();
      n_cmp++; if ({a_done, b_done} !== 2'b01 || b_rdata !== e.data || a_rdata !== ref1[11]) begin n_err++; $display("FAIL both_done_b: got %b/%h/%h expected 01/%h/%h", {a_done, b_done}, b_rdata, a_rdata, e.data, ref1[11]); end
      tick();
   endtask

   task automatic test_drop_before_sample();
      exp_t e;
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'd12; a_wdata = 32'h1234_5678;
      ref1[12] = 32'h1234_5678;
      sb.push_back('{port_b: 1'b0, data: 32'h0});
      tick();
      a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b1; b_addr = 5'd13; b_wdata = 32'hFFFF_0000;
      tick();
      b_req = 1'b0;
      e = sb.pop_front();
      n_cmp++; if ({a_done, b_done} !== {~e.port_b, e.port_b}) begin n_err++; $display("FAIL drop_done: got %b expected %b", {a_done, b_done}, {~e.port_b, e.port_b}); end
      for (int c = 3; c <= 6; c++) begin
         tick();
         n_cmp++; if (b_gnt !== 1'b0 || sram_csb_n !== 1'b1) begin n_err++; $display("FAIL drop_ignored: cycle %0d got gnt %b csb %b expected 0/1", c, b_gnt, sram_csb_n); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd12;
      sb.push_back('{port_b: 1'b0, data: ref1[12]});
      sb.push_back('{port_b: 1'b0, data: ref1[12]});
      for (int c = 1; c <= 8; c++) begin
         tick();
         n_cmp++; if (a_gnt !== (c == 1 || c == 5) || a_done !== (c == 3 || c == 7)) begin n_err++; $display("FAIL b2b_timing: cycle %0d got gnt %b done %b", c, a_gnt, a_done); end
         if (a_done) begin
            e = sb.pop_front();
            n_cmp++; if (a_rdata !== e.data) begin n_err++; $display("FAIL b2b_data: cycle %0d got %h expected %h", c, a_rdata, e.data); end
         end
         if (c == 5) a_req = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd10;
      tick();
      n_cmp++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL abort_gnt: got %b expected 1", a_gnt); end
      a_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      n_cmp++; if ({a_gnt, b_gnt, a_done, b_done, sram_csb_n, sram_we_n} !== 6'b000011) begin n_err++; $display("FAIL abort_ctl: got %b expected 000011", {a_gnt, b_gnt, a_done, b_done, sram_csb_n, sram_we_n}); end
      n_cmp++; if ({a_rdata, b_rdata} !== 64'h0 || {sram_addr, sram_din} !== 37'h0) begin n_err++; $display("FAIL abort_data: got %h/%h expected 0/0", {a_rdata, b_rdata}, {sram_addr, sram_din}); end
      rst = 1'b0;
      for (int c = 4; c <= 6; c++) begin
         tick();
         n_cmp++; if ({a_done, b_done, sram_csb_n} !== 3'b001) begin n_err++; $display("FAIL abort_quiet: cycle %0d got %b expected 001", c, {a_done, b_done, sram_csb_n}); end
      end
      b_req = 1'b1; b_we = 1'b1; b_addr = 5'd5; b_wdata = 32'h5555_AAAA;
      sb.push_back('{port_b: 1'b1, data: 32'h0});
      tick();
      n_cmp++; if ({a_gnt, b_gnt, sram_csb_n} !== 3'b010 || sram_din !== 32'h5555_AAAA) begin n_err++; $display("FAIL post_rst_gnt: got %b/%h expected 010/5555aaaa", {a_gnt, b_gnt, sram_csb_n}, sram_din); end
      b_req = 1'b0;
      tick();
      e = sb.pop_front();
      n_cmp++; if ({a_done, b_done} !== {~e.port_b, e.port_b}) begin n_err++; $display("FAIL post_rst_done: got %b expected %b", {a_done, b_done}, {~e.port_b, e.port_b}); end
      tick();
   endtask

   task automatic test_lat3();
      logic [31:0] exp_d;
      logic [31:0] last_dout;
      exp_d = {16'hCAFE, 11'd0, 5'd9};
      last_dout = 32'h0;
      t3_a_req = 1'b1; t3_a_we = 1'b0; t3_a_addr = 5'd9;
      for (int c = 1; c <= 7; c++) begin
         tick();
         n_cmp++; if (t3_a_gnt !== (c == 1) || t3_a_done !== (c == 5) || {t3_b_gnt, t3_b_done} !== 2'b00) begin n_err++; $display("FAIL lat3_timing: cycle %0d got gnt %b done %b", c, t3_a_gnt, t3_a_done); end
         if (c == 1) t3_a_req = 1'b0;
         if (c == 4) last_dout = t3_sram_dout;
         if (c == 5) begin
            n_cmp++; if (t3_a_rdata !== exp_d || t3_a_rdata !== last_dout) begin n_err++; $display("FAIL lat3_data: got %h expected %h (dout %h)", t3_a_rdata, exp_d, last_dout); end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      t3_a_req = 1'b0; t3_a_we = 1'b0; t3_a_addr = '0; t3_a_wdata = '0;
      t3_b_req = 1'b0; t3_b_we = 1'b0; t3_b_addr = '0; t3_b_wdata = '0;
      test_reset();
      test_write_a();
      test_read_b();
      test_round_robin();
      test_single_req();
      test_drop_before_sample();
      test_back_to_back();
      test_reset_mid();
      test_lat3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
